// File: rtl/i2c_reg_target.sv
// I2C register target: 7-bit device address, 16-bit register pointer, 8-bit data.
// Oversamples SCL/SDA on clk; decodes writes into wr_* strobes and serves reads from rd_data.
module i2c_reg_target #(
  parameter logic [6:0]  DEV_ADDR    = 7'h24,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_t,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [15:0] rd_addr,
  input  logic [7:0]  rd_data,
  output logic        rd_req,
  output logic        busy
);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAAck, StRegHi, StRegLo, StWrByte, StRdByte, StMAck, StIgnore
  } state_e;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_hist_q, sda_hist_q;
  logic                   scl_s, sda_s, sda_chg;
  logic                   start_det, stop_det, scl_rise, scl_fall;

  state_e      state_q, state_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic        rw_q, rw_d;
  logic        sda_q, sda_d;
  logic        busy_q, busy_d;
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  logic        rd_req_q, rd_req_d;
  logic        rd_cap_q, rd_cap_d;

  assign scl_s   = scl_sync_q[SYNC_STAGES-1];
  assign sda_s   = sda_sync_q[SYNC_STAGES-1];
  assign sda_chg = sda_s ^ sda_hist_q;

  // START/STOP win over a coincident SCL edge, which is then not a data edge.
  assign start_det = scl_hist_q & sda_hist_q & ~sda_s;
  assign stop_det  = scl_hist_q & ~sda_hist_q & sda_s;
  assign scl_rise  = scl_s & ~scl_hist_q & ~sda_chg;
  assign scl_fall  = ~scl_s & scl_hist_q & ~sda_chg;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= '0;
      rw_q       <= 1'b0;
      sda_q      <= 1'b1;
      busy_q     <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      rd_addr_q  <= '0;
      rd_req_q   <= 1'b0;
      rd_cap_q   <= 1'b0;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      rw_q       <= rw_d;
      sda_q      <= sda_d;
      busy_q     <= busy_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_addr_q  <= rd_addr_d;
      rd_req_q   <= rd_req_d;
      rd_cap_q   <= rd_cap_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    rw_d       = rw_q;
    sda_d      = sda_q;
    busy_d     = busy_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_addr_d  = rd_addr_q;
    rd_req_d   = 1'b0;
    rd_cap_d   = rd_req_q;
    // rd_data is sampled one clock after the rd_req pulse
    tx_d       = rd_cap_q ? rd_data : tx_q;

    if (start_det) begin
      state_d   = StAddr;
      bit_cnt_d = '0;
      busy_d    = 1'b1;
      sda_d     = 1'b1;
    end else if (stop_det) begin
      state_d   = StIdle;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
      sda_d     = 1'b1;
    end else begin
      unique case (state_q)
        StIdle, StIgnore: sda_d = 1'b1;
        StAddr: begin
          if (scl_rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              bit_cnt_d = '0;
              rw_d      = sda_s;
              state_d   = (shift_q[6:0] == DEV_ADDR) ? StAAck : StIgnore;
            end
          end
        end
        StAAck: begin
          if (scl_fall && bit_cnt_q == 4'd0) begin
            sda_d     = 1'b0;
            bit_cnt_d = 4'd1;
          end else if (scl_rise && bit_cnt_q == 4'd1) begin
            bit_cnt_d = '0;
            if (rw_q) begin
              rd_req_d = 1'b1;
              state_d  = StRdByte;
            end else begin
              state_d = StRegHi;
            end
          end
        end
        StRegHi, StRegLo, StWrByte: begin
          // bit_cnt 8 is the ACK slot; its rising edge commits the byte
          if (scl_rise) begin
            if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = '0;
              if (state_q == StRegHi) begin
                rd_addr_d[15:8] = shift_q;
                state_d         = StRegLo;
              end else if (state_q == StRegLo) begin
                rd_addr_d[7:0] = shift_q;
                state_d        = StWrByte;
              end else begin
                wr_valid_d = 1'b1;
                wr_addr_d  = rd_addr_q;
                wr_data_d  = shift_q;
                rd_addr_d  = rd_addr_q + 16'd1;
              end
            end else begin
              shift_d   = {shift_q[6:0], sda_s};
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end else if (scl_fall) begin
            sda_d = (bit_cnt_q == 4'd8) ? 1'b0 : 1'b1;
          end
        end
        StRdByte: begin
          if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_d     = 1'b1;
              bit_cnt_d = '0;
              state_d   = StMAck;
            end else begin
              sda_d = tx_q[3'd7 - bit_cnt_q[2:0]];
            end
          end else if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        StMAck: begin
          if (scl_rise) begin
            bit_cnt_d = '0;
            rd_addr_d = rd_addr_q + 16'd1;
            if (!sda_s) begin
              rd_req_d = 1'b1;
              state_d  = StRdByte;
            end else begin
              state_d = StIgnore;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs
  always_comb begin
    sda_o    = sda_q;
    sda_t    = sda_q;
    busy     = busy_q;
    wr_valid = wr_valid_q;
    wr_addr  = wr_addr_q;
    wr_data  = wr_data_q;
    rd_addr  = rd_addr_q;
    rd_req   = rd_req_q;
  end

endmodule

// File: tb/tb_i2c_reg_target.sv
// Bench for i2c_reg_target: bit-banged I2C master on a wired-AND bus, transaction-level model
// of the register pointer, and a per-cycle scoreboard on the write/read strobes.
module tb_i2c_reg_target;

  localparam logic [6:0] Dev = 7'h24;
  localparam int Q = 8;  // quarter SCL period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scl_m = 1'b1, sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_o, sda_t, wr_valid, rd_req, busy;
  logic [15:0] wr_addr, rd_addr;
  logic [7:0]  wr_data, rd_data;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & sda_o;
  // Register file seen by the target: a fixed function of the address
  assign rd_data = rd_addr[7:0] ^ rd_addr[15:8] ^ 8'h5A;

  i2c_reg_target #(.DEV_ADDR(7'h24), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .scl_i(scl_m), .sda_i(sda_bus), .sda_o(sda_o), .sda_t(sda_t),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_req(rd_req), .busy(busy)
  );

  int n_checks = 0, n_pass = 0;
  int wr_count = 0;
  logic [15:0] last_wr_addr = '0;
  logic [7:0]  last_wr_data = '0, last_rd = '0;
  logic        no_drive = 1'b0;

  // Model state
  logic [15:0] mdl_ptr = '0;
  logic [23:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  tb_bytes[8];

  function automatic logic [7:0] mem_f(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Per-cycle scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_valid) begin
        wr_count++;
        last_wr_addr = wr_addr;
        last_wr_data = wr_data;
        if (exp_wr.size() == 0) check("wr_unexpected", {wr_addr, wr_data}, 32'hFFFF_FFFF);
        else check("wr_strobe", {wr_addr, wr_data}, exp_wr.pop_front());
      end
      if (rd_req) begin
        if (exp_rd.size() == 0) check("rd_unexpected", {16'h0, rd_addr}, 32'hFFFF_FFFF);
        else check("rd_req_addr", rd_addr, exp_rd.pop_front());
      end
      if (wr_valid || rd_req) check("strobe_excl", wr_valid & rd_req, 0);
      if (no_drive) check("no_drive", sda_o, 1);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_bit(input logic b, output logic smp);
    sda_m = b;  tick(Q);
    scl_m = 1'b1; tick(Q);
    smp = sda_bus; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic d;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], d);
    bus_bit(1'b1, ack);
  endtask

  task automatic read_byte(output logic [7:0] b, input logic nack);
    logic d;
    for (int i = 7; i >= 0; i--) bus_bit(1'b1, b[i]);
    bus_bit(nack, d);
  endtask

  // START, {dev,W}, then n bytes from tb_bytes (pointer hi, pointer lo, data...)
  task automatic wr_txn(input logic [6:0] dev, input int n, input bit do_stop);
    logic ack;
    bit   hit;
    hit = (dev == Dev);
    i2c_start();
    write_byte({dev, 1'b0}, ack);
    check("addr_ack", ack, hit ? 0 : 1);
    for (int i = 0; i < n; i++) begin
      if (hit && i >= 2) exp_wr.push_back({mdl_ptr, tb_bytes[i]});
      write_byte(tb_bytes[i], ack);
      check("byte_ack", ack, hit ? 0 : 1);
      if (hit) begin
        if (i == 0) mdl_ptr[15:8] = tb_bytes[i];
        else if (i == 1) mdl_ptr[7:0] = tb_bytes[i];
        else mdl_ptr = mdl_ptr + 16'd1;
      end
    end
    if (do_stop) begin
      i2c_stop();
      tick(Q);
    end
  endtask

  // (Repeated) START, {Dev,R}, n bytes; master ACKs all but the last
  task automatic rd_txn(input int n);
    logic       ack;
    logic [7:0] b;
    i2c_start();
    exp_rd.push_back(mdl_ptr);
    write_byte({Dev, 1'b1}, ack);
    check("rd_addr_ack", ack, 0);
    for (int i = 0; i < n; i++) begin
      if (i != n - 1) exp_rd.push_back(mdl_ptr + 16'd1);
      read_byte(b, i == n - 1);
      check("rd_byte", b, mem_f(mdl_ptr));
      last_rd = b;
      mdl_ptr = mdl_ptr + 16'd1;
    end
    i2c_stop();
    tick(Q);
  endtask

  initial begin
    int   base;
    logic d;
    tick(3);
    check("rst_sda_o", sda_o, 1);
    check("rst_sda_t", sda_t, 1);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_rd_req", rd_req, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(Q);

    // 1: single write
    base = wr_count;
    tb_bytes[0] = 8'h01; tb_bytes[1] = 8'h03; tb_bytes[2] = 8'h00;
    wr_txn(Dev, 3, 1'b0);
    check("busy_mid", busy, 1);
    i2c_stop(); tick(Q);
    check("busy_after_stop", busy, 0);
    check("t1_count", wr_count - base, 1);
    check("t1_wr_addr", last_wr_addr, 16'h0103);
    check("t1_wr_data", last_wr_data, 8'h00);
    check("t1_rd_addr", rd_addr, 16'h0104);

    // 2: foreign address is ignored and never driven
    base = wr_count;
    no_drive = 1'b1;
    tb_bytes[0] = 8'h11; tb_bytes[1] = 8'h22;
    wr_txn(7'h30, 2, 1'b1);
    no_drive = 1'b0;
    check("t2_count", wr_count - base, 0);
    check("t2_rd_addr", rd_addr, mdl_ptr);

    // 3: burst write
    base = wr_count;
    tb_bytes[0] = 8'h30; tb_bytes[1] = 8'h10;
    tb_bytes[2] = 8'hAA; tb_bytes[3] = 8'hBB; tb_bytes[4] = 8'hCC;
    wr_txn(Dev, 5, 1'b1);
    check("t3_count", wr_count - base, 3);
    check("t3_rd_addr", rd_addr, 16'h3013);
    check("t3_last_data", last_wr_data, 8'hCC);

    // 4: set pointer, repeated START, single read with NACK
    tb_bytes[0] = 8'h00; tb_bytes[1] = 8'h00;
    wr_txn(Dev, 2, 1'b0);
    rd_txn(1);
    check("t4_byte", last_rd, 8'h5A);
    check("t4_rd_addr", rd_addr, 16'h0001);
    check("t4_busy", busy, 0);

    // 5: pointer wraps through FFFF
    base = wr_count;
    tb_bytes[0] = 8'hFF; tb_bytes[1] = 8'hFF; tb_bytes[2] = 8'h11; tb_bytes[3] = 8'h22;
    wr_txn(Dev, 4, 1'b1);
    check("t5_count", wr_count - base, 2);
    check("t5_wr_addr", last_wr_addr, 16'h0000);
    check("t5_wr_data", last_wr_data, 8'h22);
    check("t5_rd_addr", rd_addr, 16'h0001);

    // Pointer-only write, then a fresh multi-byte read starting there
    tb_bytes[0] = 8'h12; tb_bytes[1] = 8'hFE;
    wr_txn(Dev, 2, 1'b1);
    check("ptr_only_rd_addr", rd_addr, 16'h12FE);
    rd_txn(3);
    check("burst_rd_last", last_rd, 8'h49);
    check("burst_rd_addr", rd_addr, 16'h1301);

    // STOP mid data byte discards the partial byte
    base = wr_count;
    tb_bytes[0] = 8'h40; tb_bytes[1] = 8'h00;
    wr_txn(Dev, 2, 1'b0);
    for (int i = 0; i < 4; i++) bus_bit(i[0], d);
    i2c_stop(); tick(Q);
    check("partial_count", wr_count - base, 0);
    check("partial_rd_addr", rd_addr, 16'h4000);

    // 6: reset during the 4th bit of the data byte (bit value 1 keeps the bus idle-looking)
    base = wr_count;
    tb_bytes[0] = 8'h01; tb_bytes[1] = 8'h03;
    wr_txn(Dev, 2, 1'b0);
    for (int i = 7; i >= 5; i--) bus_bit(8'hD5 >> i, d);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(2);
    rst = 1'b1; tick(1);
    check("rst_mid_sda", sda_o, 1);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_rd_addr", rd_addr, 0);
    rst = 1'b0;
    mdl_ptr = '0;
    tick(Q);
    scl_m = 1'b0; tick(Q);
    i2c_stop(); tick(Q);
    check("rst_mid_count", wr_count - base, 0);

    // Reset while the target is pulling SDA low in an ACK slot
    i2c_start();
    write_byte({Dev, 1'b0}, d);
    check("ack_slot_addr_ack", d, 0);
    for (int i = 7; i >= 0; i--) bus_bit(1'b0, d);
    sda_m = 1'b1; tick(Q);
    check("ack_slot_driven", sda_o, 0);
    rst = 1'b1; tick(1);
    check("ack_slot_released", sda_o, 1);
    check("ack_slot_sda_t", sda_t, 1);
    rst = 1'b0;
    tick(Q);
    scl_m = 1'b1; tick(Q);
    scl_m = 1'b0; tick(Q);
    i2c_stop(); tick(Q);

    // Case 1 again after the aborted transactions
    base = wr_count;
    tb_bytes[0] = 8'h01; tb_bytes[1] = 8'h03; tb_bytes[2] = 8'h00;
    wr_txn(Dev, 3, 1'b1);
    check("t6_count", wr_count - base, 1);
    check("t6_wr_addr", last_wr_addr, 16'h0103);
    check("t6_rd_addr", rd_addr, 16'h0104);

    check("exp_wr_drained", exp_wr.size(), 0);
    check("exp_rd_drained", exp_rd.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
